// File: rtl/eth_phy_ipg_rx_extract_pkg.sv
// rtl/eth_phy_ipg_rx_extract_pkg.sv - shared constants, block field offsets and FSM encoding for IPG carrier extraction
package eth_phy_ipg_rx_extract_pkg;

  localparam logic [7:0] IPG_BLOCK_TYPE_DEF = 8'hA5;
  localparam logic [1:0] SYNC_DATA          = 2'b01;
  localparam logic [1:0] SYNC_CTRL          = 2'b10;

  localparam int LEN_LSB     = 8;
  localparam int LEN_W       = 3;
  localparam int SOM_BIT     = 14;
  localparam int EOM_BIT     = 15;
  localparam int PAYLOAD_LSB = 16;
  localparam int MAX_PAYLOAD = 6;
  localparam int PAYLOAD_W   = 8 * MAX_PAYLOAD;
  localparam int ENTRY_W     = 1 + LEN_W + PAYLOAD_W;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_MSG = 1'b1
  } ipg_state_e;

  // Bytes beyond LEN are zeroed so stale carrier bytes never leak downstream.
  function automatic logic [PAYLOAD_W-1:0] mask_payload(input logic [PAYLOAD_W-1:0] payload,
                                                        input logic [LEN_W-1:0] len);
    logic [PAYLOAD_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      if (LEN_W'(i) < len) m[i*8 +: 8] = payload[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/eth_phy_ipg_fifo.sv
// rtl/eth_phy_ipg_fifo.sv - synchronous fragment FIFO with in-place forcing of the last flag on the tail entry
module eth_phy_ipg_fifo
  import eth_phy_ipg_rx_extract_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  input  logic                   rewrite_last,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    tail_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign level    = count;
  assign do_rd    = rd_en && !empty;
  assign do_wr    = wr_en && (!full || do_rd);
  assign tail_ptr = wr_ptr - AW'(1);
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  // Tail rewrite and push never collide: the push lands one slot past the tail.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
    if (rewrite_last && !empty) mem[tail_ptr][WIDTH-1] <= 1'b1;
  end

endmodule

// File: rtl/eth_phy_ipg_rx_extract.sv
// rtl/eth_phy_ipg_rx_extract.sv - extracts IPG-carrier fragments from received PCS blocks into a framed message stream
module eth_phy_ipg_rx_extract
  import eth_phy_ipg_rx_extract_pkg::*;
#(
  parameter int         DATA_WIDTH     = 64,
  parameter int         HDR_WIDTH      = 2,
  parameter logic [7:0] IPG_BLOCK_TYPE = IPG_BLOCK_TYPE_DEF,
  parameter int         FIFO_DEPTH     = 16,
  parameter int         CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       encoded_rx_data,
  input  logic [HDR_WIDTH-1:0]        encoded_rx_hdr,
  input  logic                        encoded_rx_valid,
  input  logic                        rx_block_lock,
  output logic [PAYLOAD_W-1:0]        m_ipg_data,
  output logic [LEN_W-1:0]            m_ipg_len,
  output logic                        m_ipg_last,
  output logic                        m_ipg_valid,
  input  logic                        m_ipg_ready,
  output logic [CNT_WIDTH-1:0]        stat_ipg_blocks,
  output logic [CNT_WIDTH-1:0]        stat_drop,
  output logic [CNT_WIDTH-1:0]        stat_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  logic                 s_vld;
  logic                 s_lock_lost;
  logic [HDR_WIDTH-1:0] s_hdr;
  logic [7:0]           s_type;
  logic [LEN_W-1:0]     s_len;
  logic                 s_som;
  logic                 s_eom;
  logic [PAYLOAD_W-1:0] s_payload;
  logic                 unused_rsvd;

  ipg_state_e state, next_state;
  logic drop_msg, next_drop;
  logic tail_open, next_tail_open;
  logic is_carrier, len_ok, pop, can_push, fifo_empty, fifo_full;
  logic push, rewrite, want_push, new_msg;
  logic ipg_inc, err_inc, drop_inc;
  logic [ENTRY_W-1:0] fifo_rd_data;

  assign unused_rsvd = ^encoded_rx_data[13:11];

  // Input stage: one register so the framing decision sees a stable block.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_vld       <= 1'b0;
      s_lock_lost <= 1'b0;
      s_hdr       <= '0;
      s_type      <= '0;
      s_len       <= '0;
      s_som       <= 1'b0;
      s_eom       <= 1'b0;
      s_payload   <= '0;
    end else begin
      s_vld       <= encoded_rx_valid && rx_block_lock;
      s_lock_lost <= !rx_block_lock;
      s_hdr       <= encoded_rx_hdr;
      s_type      <= encoded_rx_data[7:0];
      s_len       <= encoded_rx_data[LEN_LSB +: LEN_W];
      s_som       <= encoded_rx_data[SOM_BIT];
      s_eom       <= encoded_rx_data[EOM_BIT];
      s_payload   <= encoded_rx_data[PAYLOAD_LSB +: PAYLOAD_W];
    end
  end

  assign is_carrier = s_vld && (s_hdr == SYNC_CTRL) && (s_type == IPG_BLOCK_TYPE);
  assign len_ok     = (s_len != '0) && (s_len <= LEN_W'(MAX_PAYLOAD));
  assign pop        = m_ipg_valid && m_ipg_ready;
  assign can_push   = !fifo_full || pop;

  always_comb begin
    next_state     = state;
    next_drop      = drop_msg;
    next_tail_open = tail_open;
    push           = 1'b0;
    rewrite        = 1'b0;
    want_push      = 1'b0;
    new_msg        = 1'b0;
    ipg_inc        = 1'b0;
    err_inc        = 1'b0;
    drop_inc       = 1'b0;
    if (state == ST_IN_MSG && (s_lock_lost || (s_vld && s_hdr == SYNC_DATA))) begin
      next_state     = ST_IDLE;
      err_inc        = 1'b1;
      rewrite        = tail_open;
      next_tail_open = 1'b0;
      next_drop      = 1'b0;
    end else if (is_carrier && !len_ok) begin
      err_inc = 1'b1;
    end else if (is_carrier) begin
      ipg_inc = 1'b1;
      if (s_som) begin
        new_msg   = 1'b1;
        want_push = 1'b1;
        if (state == ST_IN_MSG) begin
          err_inc = 1'b1;
          rewrite = tail_open;
        end
      end else if (state == ST_IN_MSG) begin
        want_push = 1'b1;
      end else begin
        err_inc = 1'b1;
      end
    end
    // Once a message loses a fragment, its remainder is discarded and what was queued is closed off.
    if (want_push) begin
      if (!new_msg && drop_msg) begin
        drop_inc = 1'b1;
      end else if (can_push) begin
        push = 1'b1;
      end else begin
        drop_inc = 1'b1;
        if (!new_msg) rewrite = tail_open;
      end
      next_state     = s_eom ? ST_IDLE : ST_IN_MSG;
      next_drop      = !s_eom && !push;
      next_tail_open = push && !s_eom;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      drop_msg        <= 1'b0;
      tail_open       <= 1'b0;
      stat_ipg_blocks <= '0;
      stat_drop       <= '0;
      stat_err        <= '0;
    end else begin
      state     <= next_state;
      drop_msg  <= next_drop;
      tail_open <= next_tail_open;
      if (ipg_inc && !(&stat_ipg_blocks)) stat_ipg_blocks <= stat_ipg_blocks + CNT_WIDTH'(1);
      if (drop_inc && !(&stat_drop))      stat_drop       <= stat_drop + CNT_WIDTH'(1);
      if (err_inc && !(&stat_err))        stat_err        <= stat_err + CNT_WIDTH'(1);
    end
  end

  eth_phy_ipg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (push),
    .wr_data      ({s_eom, s_len, mask_payload(s_payload, s_len)}),
    .rd_en        (pop),
    .rewrite_last (rewrite),
    .rd_data      (fifo_rd_data),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .level        (fifo_level)
  );

  assign m_ipg_valid = !fifo_empty;
  assign m_ipg_last  = fifo_rd_data[ENTRY_W-1];
  assign m_ipg_len   = fifo_rd_data[PAYLOAD_W +: LEN_W];
  assign m_ipg_data  = fifo_rd_data[PAYLOAD_W-1:0];

endmodule

// File: tb/tb_eth_phy_ipg_rx_extract.sv
// tb/tb_eth_phy_ipg_rx_extract.sv - directed self-checking bench for eth_phy_ipg_rx_extract
module tb_eth_phy_ipg_rx_extract;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] encoded_rx_data;
  logic [1:0]  encoded_rx_hdr;
  logic        encoded_rx_valid;
  logic        rx_block_lock;
  logic [47:0] m_ipg_data;
  logic [2:0]  m_ipg_len;
  logic        m_ipg_last;
  logic        m_ipg_valid;
  logic        m_ipg_ready;
  logic [15:0] stat_ipg_blocks, stat_drop, stat_err;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  eth_phy_ipg_rx_extract #(
    .DATA_WIDTH     (64),
    .HDR_WIDTH      (2),
    .IPG_BLOCK_TYPE (8'hA5),
    .FIFO_DEPTH     (4),
    .CNT_WIDTH      (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .encoded_rx_data  (encoded_rx_data),
    .encoded_rx_hdr   (encoded_rx_hdr),
    .encoded_rx_valid (encoded_rx_valid),
    .rx_block_lock    (rx_block_lock),
    .m_ipg_data       (m_ipg_data),
    .m_ipg_len        (m_ipg_len),
    .m_ipg_last       (m_ipg_last),
    .m_ipg_valid      (m_ipg_valid),
    .m_ipg_ready      (m_ipg_ready),
    .stat_ipg_blocks  (stat_ipg_blocks),
    .stat_drop        (stat_drop),
    .stat_err         (stat_err),
    .fifo_level       (fifo_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] hdr, input logic [63:0] data);
    encoded_rx_hdr   = hdr;
    encoded_rx_data  = data;
    encoded_rx_valid = 1'b1;
    @(negedge clk);
    encoded_rx_valid = 1'b0;
  endtask

  function automatic logic [63:0] carrier(input logic [2:0] len, input logic som, input logic eom,
                                          input logic [47:0] pl);
    return {pl, eom, som, 3'b000, len, 8'hA5};
  endfunction

  function automatic logic [47:0] keep(input logic [47:0] pl, input int n);
    logic [47:0] m;
    m = (n >= 6) ? {48{1'b1}} : ((48'd1 << (8 * n)) - 48'd1);
    return pl & m;
  endfunction

  task automatic head(input string tag, input logic [47:0] d, input logic [2:0] len, input logic last);
    chk({tag, "_valid"}, 64'(m_ipg_valid), 64'd1);
    chk({tag, "_data"}, 64'(m_ipg_data), 64'(d));
    chk({tag, "_len"}, 64'(m_ipg_len), 64'(len));
    chk({tag, "_last"}, 64'(m_ipg_last), 64'(last));
  endtask

  localparam logic [47:0] PA = 48'hA0A1A2A3A4A5;
  localparam logic [47:0] PB = 48'hB0B1B2B3B4B5;
  localparam logic [47:0] PC = 48'hDEADBEEFC1C2;
  localparam logic [47:0] PF = 48'hF6F5F4F3F2F1;

  initial begin
    rst = 1'b1;
    encoded_rx_data  = '0;
    encoded_rx_hdr   = 2'b00;
    encoded_rx_valid = 1'b0;
    rx_block_lock    = 1'b1;
    m_ipg_ready      = 1'b0;
    tick(2);
    chk("rst_valid", 64'(m_ipg_valid), 64'd0);
    chk("rst_data", 64'(m_ipg_data), 64'd0);
    chk("rst_len", 64'(m_ipg_len), 64'd0);
    chk("rst_last", 64'(m_ipg_last), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_counters", {16'd0, stat_ipg_blocks, stat_drop, stat_err}, 64'd0);
    rst = 1'b0;

    // single fragment, two-cycle latency
    send(2'b10, 64'h665544332211_C6_A5);
    chk("single_lat1_valid", 64'(m_ipg_valid), 64'd0);
    tick(1);
    head("single", 48'h665544332211, 3'd6, 1'b1);
    chk("single_ipg", 64'(stat_ipg_blocks), 64'd1);
    m_ipg_ready = 1'b1;
    tick(1);
    chk("single_drained", 64'(m_ipg_valid), 64'd0);
    m_ipg_ready = 1'b0;

    // three-fragment message with stall
    send(2'b10, carrier(3'd6, 1'b1, 1'b0, PA));
    send(2'b10, carrier(3'd6, 1'b0, 1'b0, PB));
    send(2'b10, carrier(3'd2, 1'b0, 1'b1, PC));
    tick(1);
    head("stall_t1", PA, 3'd6, 1'b0);
    tick(4);
    head("stall_t5", PA, 3'd6, 1'b0);
    chk("msg3_level", 64'(fifo_level), 64'd3);
    m_ipg_ready = 1'b1;
    head("msg3_b1", PA, 3'd6, 1'b0);
    tick(1);
    head("msg3_b2", PB, 3'd6, 1'b0);
    tick(1);
    head("msg3_b3", keep(PC, 2), 3'd2, 1'b1);
    tick(1);
    chk("msg3_empty", 64'(m_ipg_valid), 64'd0);
    chk("msg3_err", 64'(stat_err), 64'd0);
    chk("msg3_ipg", 64'(stat_ipg_blocks), 64'd4);
    m_ipg_ready = 1'b0;

    // abort by data block
    send(2'b10, carrier(3'd3, 1'b1, 1'b0, PA));
    send(2'b01, 64'h0123456789ABCDEF);
    tick(1);
    chk("abort_state", 64'(dut.state), 64'd0);
    chk("abort_err", 64'(stat_err), 64'd1);
    chk("abort_level", 64'(fifo_level), 64'd1);
    head("abort_frag", keep(PA, 3), 3'd3, 1'b1);
    m_ipg_ready = 1'b1;
    tick(1);
    m_ipg_ready = 1'b0;

    // bad length, then carrier without lock
    send(2'b10, carrier(3'd7, 1'b1, 1'b1, PB));
    tick(2);
    chk("badlen_err", 64'(stat_err), 64'd2);
    chk("badlen_valid", 64'(m_ipg_valid), 64'd0);
    chk("badlen_ipg", 64'(stat_ipg_blocks), 64'd5);
    rx_block_lock = 1'b0;
    send(2'b10, carrier(3'd4, 1'b1, 1'b1, PB));
    tick(2);
    chk("nolock_counters", {16'd0, stat_ipg_blocks, stat_drop, stat_err}, {16'd0, 16'd5, 16'd0, 16'd2});
    chk("nolock_level", 64'(fifo_level), 64'd0);
    rx_block_lock = 1'b1;

    // overflow: six single-fragment messages into a four-entry FIFO
    for (int k = 1; k <= 6; k++) send(2'b10, carrier(3'(k), 1'b1, 1'b1, PF));
    tick(2);
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_drop", 64'(stat_drop), 64'd2);
    chk("ovf_ipg", 64'(stat_ipg_blocks), 64'd11);
    m_ipg_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      head($sformatf("ovf_b%0d", k), keep(PF, k), 3'(k), 1'b1);
      tick(1);
    end
    chk("ovf_empty", 64'(m_ipg_valid), 64'd0);
    m_ipg_ready = 1'b0;

    // reset with three entries queued
    for (int k = 0; k < 3; k++) send(2'b10, carrier(3'd1, 1'b1, 1'b1, PA));
    tick(2);
    chk("prerst_level", 64'(fifo_level), 64'd3);
    rst = 1'b1;
    tick(1);
    chk("midrst_valid", 64'(m_ipg_valid), 64'd0);
    chk("midrst_level", 64'(fifo_level), 64'd0);
    chk("midrst_counters", {16'd0, stat_ipg_blocks, stat_drop, stat_err}, 64'd0);
    rst = 1'b0;
    send(2'b10, carrier(3'd1, 1'b1, 1'b1, PB));
    tick(1);
    chk("postrst_ipg", 64'(stat_ipg_blocks), 64'd1);
    chk("postrst_level", 64'(fifo_level), 64'd1);
    m_ipg_ready = 1'b1;
    tick(1);
    m_ipg_ready = 1'b0;

    // SOM while a message is open terminates the earlier one
    send(2'b10, carrier(3'd1, 1'b1, 1'b0, PA));
    send(2'b10, carrier(3'd2, 1'b1, 1'b1, PB));
    tick(1);
    chk("resom_err", 64'(stat_err), 64'd1);
    chk("resom_level", 64'(fifo_level), 64'd2);
    head("resom_b1", keep(PA, 1), 3'd1, 1'b1);
    m_ipg_ready = 1'b1;
    tick(1);
    head("resom_b2", keep(PB, 2), 3'd2, 1'b1);
    tick(1);
    m_ipg_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_phy_ipg_rx_extract.md
ETH_PHY_IPG_RX_EXTRACT -- requirements
Module: eth_phy_ipg_rx_extract

Interface
REQ-001 Parameter DATA_WIDTH, default 64: encoded block payload width; only 64 is legal.
REQ-002 Parameter HDR_WIDTH, default 2: sync header width; only 2 is legal.
REQ-003 Parameter IPG_BLOCK_TYPE, default 8'hA5: block type byte marking an IPG-carrier control block.
REQ-004 Parameter FIFO_DEPTH, default 16: output FIFO entries; must be a power of two and at least 2.
REQ-005 Parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-006 clk  in  1  single clock; all logic is rising-edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 encoded_rx_data  in  64  received block, descrambled; byte0 is bits [7:0].
REQ-009 encoded_rx_hdr  in  2  sync header: 2'b01 data, 2'b10 control.
REQ-010 encoded_rx_valid  in  1  qualifies data/hdr this cycle.
REQ-011 rx_block_lock  in  1  PCS block lock; when low, input is ignored.
REQ-012 m_ipg_data  out  48  payload bytes, byte0 in [7:0].
REQ-013 m_ipg_len  out  3  valid byte count, 1..6.
REQ-014 m_ipg_last  out  1  final fragment of a message.
REQ-015 m_ipg_valid / m_ipg_ready  out / in  1 / 1  valid/ready handshake.
REQ-016 stat_ipg_blocks, stat_drop, stat_err  out  CNT_WIDTH each  saturating counters.
REQ-017 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Carrier block: the block is accepted only when valid=1, lock=1, hdr=2'b10 and byte0=IPG_BLOCK_TYPE.
REQ-019 Carrier block layout:
- byte1[2:0]=LEN
- byte1[6]=SOM
- byte1[7]=EOM
- bytes2..7 = payload, with unused bytes ignored.
REQ-020 Bad carrier: a block with LEN=0 or LEN>6 is discarded and increments stat_err.
REQ-021 Message framing state machine with states IDLE and IN_MSG; reset state is IDLE.
REQ-022 IDLE, good carrier:
- SOM=1, EOM=0: push fragment, go to IN_MSG.
- SOM=1, EOM=1: push fragment with last=1, stay in IDLE.
- SOM=0: discard the fragment and increment stat_err.
REQ-023 IN_MSG, good carrier:
- SOM=0: push fragment with last=EOM; return to IDLE if EOM=1.
- SOM=1: the unfinished message is terminated by forcing last=1 on the most recent FIFO entry, if it is still unread. stat_err increments. The new fragment is then handled as it would be in IDLE.
REQ-024 In IN_MSG, a data block (hdr=2'b01) or a lock loss aborts the message. The state returns to IDLE and stat_err increments once.
REQ-025 Other control blocks (idle 0x1E, start, terminate) are transparent and do not change state.
REQ-026 Every good carrier increments stat_ipg_blocks, including carriers that are dropped.
REQ-027 FIFO full on push:
- The fragment is dropped and stat_drop increments.
- If inside a message, the rest of that message is dropped until EOM or abort. Each dropped fragment counts.
- No partial message ever reaches the output.
REQ-028 Output timing:
- Latency from input block to m_ipg_valid is 2 cycles when the FIFO is empty.
- Throughput is one fragment per cycle.
- Push and pop in the same cycle are permitted when the FIFO is full.
REQ-029 Handshake: m_ipg_data, len and last are held stable while valid=1 and ready=0; valid never deasserts without a transfer.
REQ-030 Counters saturate at all-ones and do not wrap.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH; fifo_level ranges from 0 to FIFO_DEPTH inclusive.

Reset
REQ-032 On rst=1:
- FSM goes to IDLE and the FIFO is emptied.
- m_ipg_valid=0, m_ipg_data=0, m_ipg_len=0, m_ipg_last=0.
- All stat counters=0 and fifo_level=0.
REQ-033 A reset mid-message discards all buffered fragments; counting restarts cleanly on the cycle after reset deasserts.

Structure
REQ-034 A shared package holds:
- IPG_BLOCK_TYPE default
- SYNC_DATA=2'b01 and SYNC_CTRL=2'b10
- field offsets LEN/SOM/EOM
- max payload of 6 bytes
- the FSM state enum
REQ-035 One sub-module, eth_phy_ipg_fifo, is a synchronous FIFO.
- Entry is {last, len, data}, 52 bits.
- It supports a rewrite of the last field on the tail entry.

Verification
REQ-036 Single fragment: hdr=10, data=64'h665544332211_C6_A5 -> one beat: data=48'h665544332211, len=6, last=1; stat_ipg_blocks=1.
REQ-037 Three-fragment message: SOM-only len 6, middle len 6, EOM-only len 2; ready held low for 5 cycles -> three beats in order with outputs stable while stalled; last=1 only on the third.
REQ-038 Abort: SOM fragment, then hdr=01 data block -> FSM in IDLE; stat_err=1; the already-queued fragment is emitted with last forced to 1.
REQ-039 Overflow: FIFO_DEPTH=4 with ready=0; six single-fragment messages -> fifo_level=4, stat_drop=2; draining yields the first four messages intact.
REQ-040 Bad length and lock: LEN=7 -> stat_err=1 with no output; a carrier arriving while rx_block_lock=0 -> no change at all.
REQ-041 Reset mid-stream: rst asserted with 3 entries queued -> the next cycle shows valid=0, fifo_level=0 and counters=0.
